flit_mux: RTL and testbench
===========================

# flit_mux

Registered 2:1 flit multiplexer for the NoC router datapath. Selects one of two input flit channels (data, valid, virtual-channel id) under a one-hot select vector and drives the chosen channel onto a single output port one clock later. It is content-agnostic: flit type fields (head/data/tail/none) pass through unmodified. It is also the unit characterized for per-flit switching energy.

## Interface
- DATAW, 65: MSB index of flit bus; flit is DATAW+1 bits = {type[1:0], payload[63:0]} at default.
- VCHW, 1: MSB index of virtual-channel id.
- PORT, 4: MSB index of select vector; select is PORT+1 bits.

Ports:
- clk  input  1  Clock; all state updates on rising edge.
- rst_  input  1  Reset; asynchronous, active-low.
- idata_0  input  DATAW+1  Flit on input channel 0.
- ivalid_0  input  1  Flit-valid, channel 0.
- ivch_0  input  VCHW+1  VC id, channel 0.
- idata_1  input  DATAW+1  Flit on input channel 1.
- ivalid_1  input  1  Flit-valid, channel 1.
- ivch_1  input  VCHW+1  VC id, channel 1.
- sel  input  PORT+1  One-hot select; bit 0 selects channel 0, bit 1 selects channel 1; bits 2..PORT ignored.
- odata  output  DATAW+1  Selected flit, registered.
- ovalid  output  1  Selected valid, registered.
- ovch  output  VCHW+1  Selected VC id, registered.

## Operation
- Select decode uses sel[1:0] only:
  - 2'b01: channel 0.
  - 2'b10: channel 1.
  - 2'b00 or 2'b11: no channel selected (idle).
- Selected channel, each rising edge:
  - ovalid <= ivalid_x.
  - If ivalid_x = 1: odata <= idata_x and ovch <= ivch_x.
  - If ivalid_x = 0: odata and ovch hold their previous values. This minimizes output toggling.
- Idle select: ovalid <= 0; odata and ovch hold.
- The unselected channel has no effect on outputs.
- Flits are passed bit-exact with no interpretation of the type field.
- No buffering, arbitration or backpressure. The upstream controller guarantees sel is stable for a packet's duration.

## Timing
- Latency: exactly 1 cycle. Inputs and sel sampled at edge N appear on outputs after edge N.
- Throughput: one flit per cycle, sustained with no bubbles.
- sel changes take effect at the same edge they are sampled. No extra cycle is needed on switch.
- Reset (rst_ = 0, asynchronous, independent of clk): odata = 0, ovalid = 0, ovch = 0 immediately.
  - Outputs hold 0 while rst_ is low.
  - First load occurs at the first rising edge after rst_ deasserts.
- Reset asserted mid-packet: outputs clear immediately. The partial packet is dropped and is not replayed.
- No combinational path from any input to any output.

## Test plan
- Reset: rst_ = 0 with random inputs, sel = 5'b10 -> odata = 0, ovalid = 0, ovch = 0 with no clock edge. All stay 0 until the first edge after rst_ = 1.
- Channel-1 packet: sel = 5'b10, ivalid_1 = 1, stream head {HEAD, 32'h0, 32'h04}, 20 data flits, then tail.
  - Expect: each flit appears on odata one cycle later, ovalid = 1 throughout, ovch = ivch_1.
  - Channel-0 traffic {HEAD, 32'h0, 32'h09} is never seen on outputs.
- Channel 0 with switch: sel = 5'b01 streaming channel 0, then sel = 5'b10 on the next cycle -> output switches to channel-1 flits exactly one cycle after the sel change, with no gap.
- Invalid hold: selected ivalid drops to 0 while idata changes to {NONE, 32'h0} -> ovalid = 0 next cycle; odata and ovch keep the last valid flit.
- Idle select: sel = 5'b00, then 5'b11, with both channels valid -> ovalid = 0 and odata unchanged. Bits sel[4:2] toggling with sel[1:0] = 2'b10 does not affect output.
- Reset mid-packet: assert rst_ during data flit 10 -> outputs clear asynchronously. After release, the next valid flit appears one cycle after sampling.

Source files
------------

// File: rtl/flit_mux.sv
// flit_mux -- registered 2:1 flit multiplexer for the NoC router datapath.
//
// Picks one of two input flit channels under a one-hot select and registers
// it onto a single output port. Output latency is one clock. Flit contents,
// including the type field, pass through bit-exact.
//
// Parameters
//   DATAW  MSB index of the flit bus (flit is DATAW+1 bits)
//   VCHW   MSB index of the virtual-channel id
//   PORT   MSB index of the select vector (only sel[1:0] is decoded)
//
// Ports
//   clk              clock, rising edge
//   rst_             asynchronous active-low reset, clears all outputs
//   idata_0/1        input flit, channel 0/1
//   ivalid_0/1       input flit valid, channel 0/1
//   ivch_0/1         input VC id, channel 0/1
//   sel              select: 2'b01 -> ch0, 2'b10 -> ch1, else idle
//   odata            registered selected flit
//   ovalid           registered selected valid
//   ovch             registered selected VC id
module flit_mux #(
  parameter int DATAW = 65,
  parameter int VCHW  = 1,
  parameter int PORT  = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   idata_0,
  input  logic             ivalid_0,
  input  logic [VCHW:0]    ivch_0,
  input  logic [DATAW:0]   idata_1,
  input  logic             ivalid_1,
  input  logic [VCHW:0]    ivch_1,
  input  logic [PORT:0]    sel,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch
);

  typedef struct packed {
    logic [DATAW:0] data;
    logic [VCHW:0]  vch;
  } flit_t;

  // Upper select bits are reserved for wider routers and have no effect here.
  logic unused_sel;
  assign unused_sel = ^sel[PORT:2];

  logic  sel0, sel1;
  logic  vld_d, vld_q;
  flit_t flit_d, flit_q;

  always_comb begin
    sel0   = (sel[1:0] == 2'b01);
    sel1   = (sel[1:0] == 2'b10);
    // 2'b00 and 2'b11 both decode to idle: neither term fires.
    vld_d  = (sel0 & ivalid_0) | (sel1 & ivalid_1);
    flit_d = sel1 ? flit_t'{data: idata_1, vch: ivch_1}
                  : flit_t'{data: idata_0, vch: ivch_0};
  end

  // Payload/VC only load on a valid selected flit; otherwise they hold so
  // the output bus does not toggle on bubbles or idle cycles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld_q  <= 1'b0;
      flit_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (vld_d) flit_q <= flit_d;
    end
  end

  assign odata  = flit_q.data;
  assign ovch   = flit_q.vch;
  assign ovalid = vld_q;

endmodule

// File: tb/tb_flit_mux.sv
// Directed testbench for flit_mux. Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit after the following rising edge.
module tb_flit_mux;
  localparam int DATAW = 65;
  localparam int VCHW  = 1;
  localparam int PORT  = 4;
  localparam logic [1:0] NONE = 2'd0, HEAD = 2'd1, DATA = 2'd2, TAIL = 2'd3;

  logic             clk = 1'b0;
  logic             rst_;
  logic [DATAW:0]   idata_0, idata_1, odata;
  logic             ivalid_0, ivalid_1, ovalid;
  logic [VCHW:0]    ivch_0, ivch_1, ovch;
  logic [PORT:0]    sel;

  int pass_cnt = 0;
  int total_cnt = 0;

  flit_mux #(.DATAW(DATAW), .VCHW(VCHW), .PORT(PORT)) dut (
    .clk(clk), .rst_(rst_),
    .idata_0(idata_0), .ivalid_0(ivalid_0), .ivch_0(ivch_0),
    .idata_1(idata_1), .ivalid_1(ivalid_1), .ivch_1(ivch_1),
    .sel(sel),
    .odata(odata), .ovalid(ovalid), .ovch(ovch)
  );

  always #5 clk = ~clk;

  function automatic logic [DATAW:0] mk(input logic [1:0] t, input logic [31:0] lo);
    return {t, 32'h0, lo};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_     = 1'b0;
    sel      = 5'b00010;
    idata_0  = {2'b10, $urandom(), $urandom()};
    idata_1  = {2'b01, $urandom(), $urandom()};
    ivalid_0 = 1'b1; ivalid_1 = 1'b1;
    ivch_0   = 2'd2; ivch_1 = 2'd3;
    #1;
    total_cnt++;
    if ({odata, ovalid, ovch} !== '0)
      $display("FAIL reset_async: got d=%h v=%b c=%h want all zero", odata, ovalid, ovch);
    else pass_cnt++;
    cyc(); cyc();
    total_cnt++;
    if ({odata, ovalid, ovch} !== '0)
      $display("FAIL reset_hold: got d=%h v=%b c=%h want all zero", odata, ovalid, ovch);
    else pass_cnt++;
    // Release mid-cycle; nothing loads until the next edge.
    #2 rst_ = 1'b1;
    idata_1 = mk(HEAD, 32'h55);
    ivch_1  = 2'd1;
    #1;
    total_cnt++;
    if ({odata, ovalid, ovch} !== '0)
      $display("FAIL reset_release_no_edge: got d=%h v=%b c=%h want all zero", odata, ovalid, ovch);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (odata !== mk(HEAD, 32'h55) || ovalid !== 1'b1 || ovch !== 2'd1)
      $display("FAIL reset_first_load: got d=%h v=%b c=%h want d=%h v=1 c=1",
               odata, ovalid, ovch, mk(HEAD, 32'h55));
    else pass_cnt++;
  endtask

  task automatic test_ch1_packet();
    logic [DATAW:0] f;
    sel = 5'b00010;
    idata_0 = mk(HEAD, 32'h09); ivalid_0 = 1'b1; ivch_0 = 2'd0;
    ivalid_1 = 1'b1; ivch_1 = 2'd1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)       f = mk(HEAD, 32'h04);
      else if (i == 21) f = mk(TAIL, 32'hA000_0000 + i);
      else              f = mk(DATA, 32'h1000_0000 + i);
      idata_1 = f;
      cyc();
      total_cnt++;
      if (odata !== f || ovalid !== 1'b1 || ovch !== 2'd1)
        $display("FAIL ch1_flit%0d: got d=%h v=%b c=%h want d=%h v=1 c=1",
                 i, odata, ovalid, ovch, f);
      else pass_cnt++;
    end
  endtask

  task automatic test_switch();
    ivch_0 = 2'd2; ivch_1 = 2'd3;
    ivalid_0 = 1'b1; ivalid_1 = 1'b1;
    idata_1 = mk(DATA, 32'hBBBB_0000);
    sel = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      idata_0 = mk(DATA, 32'hAAAA_0000 + i);
      cyc();
      total_cnt++;
      if (odata !== mk(DATA, 32'hAAAA_0000 + i) || ovalid !== 1'b1 || ovch !== 2'd2)
        $display("FAIL switch_ch0_%0d: got d=%h v=%b c=%h want d=%h v=1 c=2",
                 i, odata, ovalid, ovch, mk(DATA, 32'hAAAA_0000 + i));
      else pass_cnt++;
    end
    sel = 5'b00010;
    for (int i = 0; i < 2; i++) begin
      idata_1 = mk(DATA, 32'hBBBB_0001 + i);
      cyc();
      total_cnt++;
      if (odata !== mk(DATA, 32'hBBBB_0001 + i) || ovalid !== 1'b1 || ovch !== 2'd3)
        $display("FAIL switch_ch1_%0d: got d=%h v=%b c=%h want d=%h v=1 c=3",
                 i, odata, ovalid, ovch, mk(DATA, 32'hBBBB_0001 + i));
      else pass_cnt++;
    end
  endtask

  task automatic test_invalid_hold();
    // Last valid output is {DATA, BBBB_0002} on VC 3.
    ivalid_1 = 1'b0;
    idata_1  = mk(NONE, 32'h0);
    ivch_1   = 2'd0;
    cyc();
    total_cnt++;
    if (ovalid !== 1'b0 || odata !== mk(DATA, 32'hBBBB_0002) || ovch !== 2'd3)
      $display("FAIL invalid_hold: got d=%h v=%b c=%h want d=%h v=0 c=3",
               odata, ovalid, ovch, mk(DATA, 32'hBBBB_0002));
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ovalid !== 1'b0 || odata !== mk(DATA, 32'hBBBB_0002) || ovch !== 2'd3)
      $display("FAIL invalid_hold2: got d=%h v=%b c=%h want d=%h v=0 c=3",
               odata, ovalid, ovch, mk(DATA, 32'hBBBB_0002));
    else pass_cnt++;
  endtask

  task automatic test_idle_select();
    logic [PORT:0] hi_sel [3];
    hi_sel[0] = 5'b11110; hi_sel[1] = 5'b00110; hi_sel[2] = 5'b10110;
    ivalid_0 = 1'b1; ivalid_1 = 1'b1;
    idata_0 = mk(DATA, 32'hC0C0_0000); ivch_0 = 2'd0;
    idata_1 = mk(DATA, 32'hD1D1_0000); ivch_1 = 2'd1;
    sel = 5'b00000;
    cyc();
    total_cnt++;
    if (ovalid !== 1'b0 || odata !== mk(DATA, 32'hBBBB_0002) || ovch !== 2'd3)
      $display("FAIL idle_00: got d=%h v=%b c=%h want d=%h v=0 c=3",
               odata, ovalid, ovch, mk(DATA, 32'hBBBB_0002));
    else pass_cnt++;
    sel = 5'b00011;
    cyc();
    total_cnt++;
    if (ovalid !== 1'b0 || odata !== mk(DATA, 32'hBBBB_0002) || ovch !== 2'd3)
      $display("FAIL idle_11: got d=%h v=%b c=%h want d=%h v=0 c=3",
               odata, ovalid, ovch, mk(DATA, 32'hBBBB_0002));
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      sel = hi_sel[i];
      idata_1 = mk(DATA, 32'hD1D1_0010 + i);
      cyc();
      total_cnt++;
      if (odata !== mk(DATA, 32'hD1D1_0010 + i) || ovalid !== 1'b1 || ovch !== 2'd1)
        $display("FAIL upper_sel_%0d: got d=%h v=%b c=%h want d=%h v=1 c=1",
                 i, odata, ovalid, ovch, mk(DATA, 32'hD1D1_0010 + i));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_packet();
    sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd1;
    for (int i = 0; i <= 10; i++) begin
      idata_1 = (i == 0) ? mk(HEAD, 32'h04) : mk(DATA, 32'hE000_0000 + i);
      cyc();
    end
    // Output now shows data flit 10; hit reset between edges.
    #2 rst_ = 1'b0;
    #1;
    total_cnt++;
    if ({odata, ovalid, ovch} !== '0)
      $display("FAIL midpkt_async_clear: got d=%h v=%b c=%h want all zero", odata, ovalid, ovch);
    else pass_cnt++;
    idata_1 = mk(DATA, 32'hE000_000B);
    cyc();
    total_cnt++;
    if ({odata, ovalid, ovch} !== '0)
      $display("FAIL midpkt_hold_clear: got d=%h v=%b c=%h want all zero", odata, ovalid, ovch);
    else pass_cnt++;
    #2 rst_ = 1'b1;
    idata_1 = mk(DATA, 32'hE000_000C);
    cyc();
    total_cnt++;
    if (odata !== mk(DATA, 32'hE000_000C) || ovalid !== 1'b1 || ovch !== 2'd1)
      $display("FAIL midpkt_resume: got d=%h v=%b c=%h want d=%h v=1 c=1",
               odata, ovalid, ovch, mk(DATA, 32'hE000_000C));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ch1_packet();
    test_switch();
    test_invalid_hold();
    test_idle_select();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
